// File: rtl/timing_sequencer.sv
// Purpose: steps the 3-bit timing code (T0..T(MAX_CODE-1)) for the control-unit timing decoder and checks the decoder's one-hot feedback.
// Latency: one clock from a start/stall/sc_clr/halt_req edge to the updated timing_code; all outputs are registered.
// Backpressure: none; stall holds the current code in RUN, and requests are acted on every cycle without handshake.
module timing_sequencer #(
  parameter int MAX_CODE = 7,
  parameter int CNT_W    = 8,
  parameter int FB_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             sc_clr,
  input  logic             halt_req,
  input  logic [7:0]       timing_fb,
  output logic [2:0]       timing_code,
  output logic             running,
  output logic             halted,
  output logic             overflow,
  output logic             fb_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Highest legal code; stepping beyond it ends the sequence in HALT.
  localparam logic [2:0] MAX_C = 3'(MAX_CODE);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       code_nxt;
  logic             ovf_nxt;
  logic             fb_err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       fb_expected;
  logic             fb_mismatch;

  // Decoder model: code 0 selects nothing, code k selects one-hot bit k-1.
  always_comb begin
    fb_expected = 8'h00;
    if (timing_code != 3'd0) begin
      fb_expected = 8'h01 << (timing_code - 3'd1);
    end
    fb_mismatch = (FB_CHECK != 0) && (timing_fb != fb_expected);
  end

  // Next-state and next-output logic; in RUN the priority is halt > clear > stall > step.
  always_comb begin
    state_nxt  = state;
    code_nxt   = timing_code;
    ovf_nxt    = overflow;
    fb_err_nxt = fb_err | fb_mismatch;
    cnt_nxt    = instr_count;
    unique case (state)
      S_IDLE: begin
        code_nxt = 3'd0;
        if (start) begin
          state_nxt = S_RUN;
          code_nxt  = 3'd1;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_nxt = S_HALT;
          code_nxt  = 3'd0;
        end else if (sc_clr) begin
          code_nxt = 3'd1;
          cnt_nxt  = instr_count + CNT_W'(1);
        end else if (stall) begin
          code_nxt = timing_code;
        end else if (timing_code < MAX_C) begin
          code_nxt = timing_code + 3'd1;
        end else begin
          ovf_nxt   = 1'b1;
          state_nxt = S_HALT;
          code_nxt  = 3'd0;
        end
      end
      S_HALT: begin
        code_nxt = 3'd0;
        // Restart clears the sticky error flags; a mismatch seen this cycle is discarded too.
        if (start) begin
          state_nxt  = S_RUN;
          code_nxt   = 3'd1;
          ovf_nxt    = 1'b0;
          fb_err_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        code_nxt  = 3'd0;
      end
    endcase
  end

  // State and registered outputs; running/halted are decoded from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timing_code <= 3'd0;
      running     <= 1'b0;
      halted      <= 1'b0;
      overflow    <= 1'b0;
      fb_err      <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      timing_code <= code_nxt;
      running     <= (state_nxt == S_RUN);
      halted      <= (state_nxt == S_HALT);
      overflow    <= ovf_nxt;
      fb_err      <= fb_err_nxt;
      instr_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
module tb_timing_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       sc_clr;
  logic       halt_req;
  logic [7:0] timing_fb;
  logic [2:0] timing_code;
  logic       running;
  logic       halted;
  logic       overflow;
  logic       fb_err;
  logic [7:0] instr_count;

  logic [2:0] code2;
  logic       running2;
  logic       halted2;
  logic       overflow2;
  logic       fb_err2;
  logic [7:0] count2;

  logic       fb_force;
  logic [7:0] fb_val;

  int n_checks;
  int n_fail;

  timing_sequencer #(.MAX_CODE(7), .CNT_W(8), .FB_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .sc_clr(sc_clr),
    .halt_req(halt_req), .timing_fb(timing_fb), .timing_code(timing_code),
    .running(running), .halted(halted), .overflow(overflow), .fb_err(fb_err),
    .instr_count(instr_count)
  );

  timing_sequencer #(.MAX_CODE(7), .CNT_W(8), .FB_CHECK(0)) dut_nochk (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .sc_clr(sc_clr),
    .halt_req(halt_req), .timing_fb(timing_fb), .timing_code(code2),
    .running(running2), .halted(halted2), .overflow(overflow2), .fb_err(fb_err2),
    .instr_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder: code 0 -> nothing, code k -> bit k-1.
  function automatic logic [7:0] dec(input logic [2:0] c);
    logic [7:0] one;
    one = 8'h01;
    if (c == 3'd0) return 8'h00;
    return one << (c - 3'd1);
  endfunction

  assign timing_fb = fb_force ? fb_val : dec(timing_code);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stall = 0; sc_clr = 0; halt_req = 0;
    fb_force = 0; fb_val = 8'h00;
    #1;
    n_checks++;
    if ({timing_code, running, halted, overflow, fb_err, instr_count} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got code=%0d run=%0b halt=%0b ovf=%0b fberr=%0b cnt=%0d, expected all 0",
               timing_code, running, halted, overflow, fb_err, instr_count);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (timing_code !== 3'd0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got code=%0d run=%0b, expected code=0 run=0", timing_code, running);
    end
  endtask

  task automatic test_sequence();
    start = 1; tick(); start = 0;
    n_checks++;
    if (timing_code !== 3'd1 || running !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL start_code1: got code=%0d run=%0b halt=%0b, expected 1 1 0", timing_code, running, halted);
    end
    for (int k = 2; k <= 7; k++) begin
      tick();
      n_checks++;
      if (timing_code !== 3'(k) || running !== 1'b1) begin
        n_fail++;
        $display("FAIL step_code: got code=%0d run=%0b, expected code=%0d run=1", timing_code, running, k);
      end
    end
    n_checks++;
    if (fb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_fb_err: got %0b, expected 0", fb_err);
    end
  endtask

  task automatic test_overflow();
    tick();
    n_checks++;
    if (overflow !== 1'b1 || halted !== 1'b1 || timing_code !== 3'd0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_halt: got ovf=%0b halt=%0b code=%0d run=%0b, expected 1 1 0 0",
               overflow, halted, timing_code, running);
    end
    tick();
    n_checks++;
    if (timing_code !== 3'd0 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_hold: got code=%0d halt=%0b, expected code=0 halt=1", timing_code, halted);
    end
    start = 1; tick(); start = 0;
    n_checks++;
    if (timing_code !== 3'd1 || overflow !== 1'b0 || halted !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_ovf: got code=%0d ovf=%0b halt=%0b run=%0b, expected 1 0 0 1",
               timing_code, overflow, halted, running);
    end
  endtask

  task automatic test_stall_clear();
    tick(); tick();
    n_checks++;
    if (timing_code !== 3'd3) begin
      n_fail++;
      $display("FAIL reach_code3: got %0d, expected 3", timing_code);
    end
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (timing_code !== 3'd3 || running !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got code=%0d run=%0b, expected code=3 run=1", timing_code, running);
      end
    end
    sc_clr = 1; tick(); sc_clr = 0; stall = 0;
    n_checks++;
    if (timing_code !== 3'd1 || instr_count !== 8'd1) begin
      n_fail++;
      $display("FAIL clr_beats_stall: got code=%0d cnt=%0d, expected code=1 cnt=1", timing_code, instr_count);
    end
  endtask

  task automatic test_halt_priority();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (timing_code !== 3'd5) begin
      n_fail++;
      $display("FAIL reach_code5: got %0d, expected 5", timing_code);
    end
    halt_req = 1; sc_clr = 1; tick(); sc_clr = 0;
    n_checks++;
    if (halted !== 1'b1 || running !== 1'b0 || timing_code !== 3'd0 || instr_count !== 8'd1) begin
      n_fail++;
      $display("FAIL halt_beats_clr: got halt=%0b run=%0b code=%0d cnt=%0d, expected 1 0 0 1",
               halted, running, timing_code, instr_count);
    end
    start = 1; tick(); start = 0;
    n_checks++;
    if (running !== 1'b1 || halted !== 1'b0 || timing_code !== 3'd1) begin
      n_fail++;
      $display("FAIL start_beats_halt: got run=%0b halt=%0b code=%0d, expected 1 0 1", running, halted, timing_code);
    end
    tick();
    n_checks++;
    if (halted !== 1'b1 || timing_code !== 3'd0) begin
      n_fail++;
      $display("FAIL halt_in_run_next: got halt=%0b code=%0d, expected halt=1 code=0", halted, timing_code);
    end
    halt_req = 0;
    start = 1; tick(); start = 0;
    n_checks++;
    if (timing_code !== 3'd1 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_code1: got code=%0d run=%0b, expected 1 1", timing_code, running);
    end
  endtask

  task automatic test_fb_err();
    tick();
    fb_force = 1; fb_val = 8'h04; stall = 1;
    tick();
    fb_force = 0; stall = 0;
    n_checks++;
    if (fb_err !== 1'b1 || timing_code !== 3'd2) begin
      n_fail++;
      $display("FAIL fb_mismatch: got fberr=%0b code=%0d, expected fberr=1 code=2", fb_err, timing_code);
    end
    n_checks++;
    if (fb_err2 !== 1'b0 || code2 !== 3'd2) begin
      n_fail++;
      $display("FAIL fb_disabled: got fberr=%0b code=%0d, expected fberr=0 code=2", fb_err2, code2);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (fb_err !== 1'b1) begin
        n_fail++;
        $display("FAIL fb_sticky: got %0b at code %0d, expected 1", fb_err, timing_code);
      end
    end
    halt_req = 1; tick(); halt_req = 0;
    n_checks++;
    if (fb_err !== 1'b1 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL fb_sticky_halt: got fberr=%0b halt=%0b, expected 1 1", fb_err, halted);
    end
    start = 1; tick(); start = 0;
    n_checks++;
    if (fb_err !== 1'b0 || timing_code !== 3'd1 || instr_count !== 8'd1) begin
      n_fail++;
      $display("FAIL fb_clear_on_start: got fberr=%0b code=%0d cnt=%0d, expected 0 1 1", fb_err, timing_code, instr_count);
    end
  endtask

  task automatic test_count_wrap();
    sc_clr = 1;
    for (int i = 0; i < 254; i++) tick();
    n_checks++;
    if (instr_count !== 8'd255 || timing_code !== 3'd1) begin
      n_fail++;
      $display("FAIL count_255: got cnt=%0d code=%0d, expected 255 1", instr_count, timing_code);
    end
    tick();
    sc_clr = 0;
    n_checks++;
    if (instr_count !== 8'd0 || overflow !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL count_wrap: got cnt=%0d ovf=%0b run=%0b, expected 0 0 1", instr_count, overflow, running);
    end
  endtask

  task automatic test_reset_mid_run();
    tick(); tick(); tick();
    n_checks++;
    if (timing_code !== 3'd4) begin
      n_fail++;
      $display("FAIL reach_code4: got %0d, expected 4", timing_code);
    end
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({timing_code, running, halted, overflow, fb_err} !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset: got code=%0d run=%0b halt=%0b ovf=%0b fberr=%0b, expected all 0",
               timing_code, running, halted, overflow, fb_err);
    end
    tick();
    rst_n = 1;
    stall = 1; sc_clr = 1; halt_req = 1;
    tick();
    stall = 0; sc_clr = 0; halt_req = 0;
    n_checks++;
    if (timing_code !== 3'd0 || running !== 1'b0 || halted !== 1'b0 || instr_count !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_ignores: got code=%0d run=%0b halt=%0b cnt=%0d, expected all 0",
               timing_code, running, halted, instr_count);
    end
    fb_force = 1; fb_val = 8'h01;
    tick();
    fb_force = 0;
    n_checks++;
    if (fb_err !== 1'b1 || fb_err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_fb_check: got fberr=%0b nochk=%0b, expected 1 0", fb_err, fb_err2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequence();
    test_overflow();
    test_stall_clear();
    test_halt_priority();
    test_fb_err();
    test_count_wrap();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
